gate_net_seq_eval: RTL and testbench



---
 rtl/gate_net_seq_eval.sv | 178 +++++++++++++++++
 tb/tb_gate_net_seq_eval.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_net_seq_eval.sv
// gate_net_seq_eval: programmable 2-input/AO21 gate network evaluated one gate per cycle, result held in DONE until out_ready.
// Define GATE_NET_STATS_EN to add the stat_count (output handshakes) and stat_rej (rejected writes) counters.
module gate_net_seq_eval #(
  parameter int  NUM_IN    = 113,
  parameter int  NUM_GATES = 40,
  parameter int  NUM_OUT   = 2,
  parameter int  IDX_W     = $clog2(2 + NUM_IN + NUM_GATES),
  localparam int ADDR_W    = $clog2(NUM_GATES),
  localparam int PROG_W    = 3 + 3 * IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_IN-1:0]  in_bits,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_bits,
  output logic               busy,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [PROG_W-1:0]  prog_data,
  output logic               prog_err
`ifdef GATE_NET_STATS_EN
  ,
  output logic [31:0]        stat_count,
  output logic [15:0]        stat_rej
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(NUM_GATES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [NUM_IN-1:0]   in_q, in_d;
  logic [NUM_GATES-1:0] res_q, res_d;
  logic                in_ready_q;
  logic                prog_err_q, prog_err_d;

  logic [2:0]          op_q [NUM_GATES];
  logic [IDX_W-1:0]    a_q  [NUM_GATES];
  logic [IDX_W-1:0]    b_q  [NUM_GATES];
  logic [IDX_W-1:0]    c_q  [NUM_GATES];

  logic [2:0]          wr_op;
  logic [IDX_W-1:0]    wr_a, wr_b, wr_c;
  logic                wr_addr_ok, wr_ok;

  logic [2:0]          cur_op;
  logic                va, vb, vc, gate_val;

  assign wr_op      = prog_data[PROG_W-1 -: 3];
  assign wr_a       = prog_data[3*IDX_W-1 -: IDX_W];
  assign wr_b       = prog_data[2*IDX_W-1 -: IDX_W];
  assign wr_c       = prog_data[IDX_W-1:0];
  assign wr_addr_ok = ({1'b0, prog_addr} < (ADDR_W + 1)'(NUM_GATES));
  assign wr_ok      = prog_we && wr_addr_ok && (state_q == IDLE);
  assign prog_err_d = prog_we && !wr_ok;

  // Node lookup: consts, latched inputs, gate results; unmapped indices read 0.
  function automatic logic node_val(input logic [IDX_W-1:0]     idx,
                                    input logic [NUM_IN-1:0]    x,
                                    input logic [NUM_GATES-1:0] r);
    logic v;
    v = 1'b0;
    if (idx == IDX_W'(1)) v = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (idx == IDX_W'(k + 2)) v = x[k];
    end
    for (int g = 0; g < NUM_GATES; g++) begin
      if (idx == IDX_W'(NUM_IN + 2 + g)) v = r[g];
    end
    return v;
  endfunction

  always_comb begin
    cur_op = op_q[pc_q];
    va     = node_val(a_q[pc_q], in_q, res_q);
    vb     = node_val(b_q[pc_q], in_q, res_q);
    vc     = node_val(c_q[pc_q], in_q, res_q);
    case (cur_op)
      3'd0:    gate_val = va & vb;
      3'd1:    gate_val = va | vb;
      3'd2:    gate_val = va ^ vb;
      3'd3:    gate_val = ~(va & vb);
      3'd4:    gate_val = ~(va | vb);
      3'd5:    gate_val = ~(va ^ vb);
      3'd6:    gate_val = va | (vb & vc);
      default: gate_val = va;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    in_d    = in_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in_d    = in_bits;
          res_d   = '0;
          pc_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[pc_q] = gate_val;
        if (pc_q == PC_LAST) begin
          state_d = DONE;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      in_q       <= '0;
      res_q      <= '0;
      in_ready_q <= 1'b1;
      prog_err_q <= 1'b0;
      for (int g = 0; g < NUM_GATES; g++) begin
        op_q[g] <= 3'd7;
        a_q[g]  <= '0;
        b_q[g]  <= '0;
        c_q[g]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      in_q       <= in_d;
      res_q      <= res_d;
      in_ready_q <= (state_d == IDLE);
      prog_err_q <= prog_err_d;
      if (wr_ok) begin
        op_q[prog_addr] <= wr_op;
        a_q[prog_addr]  <= wr_a;
        b_q[prog_addr]  <= wr_b;
        c_q[prog_addr]  <= wr_c;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign prog_err  = prog_err_q;
  assign out_bits  = out_valid ? res_q[NUM_GATES-NUM_OUT +: NUM_OUT] : '0;

`ifdef GATE_NET_STATS_EN
  logic [31:0] stat_count_q;
  logic [15:0] stat_rej_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count_q <= '0;
      stat_rej_q   <= '0;
    end else begin
      if (out_valid && out_ready && (stat_count_q != '1)) stat_count_q <= stat_count_q + 1'b1;
      if (prog_err_q && (stat_rej_q != '1))               stat_rej_q   <= stat_rej_q + 1'b1;
    end
  end

  assign stat_count = stat_count_q;
  assign stat_rej   = stat_rej_q;
`endif

endmodule

// File: tb/tb_gate_net_seq_eval.sv
// Bench for gate_net_seq_eval: directed program cases plus random programs against a sequential network model.
module tb_gate_net_seq_eval;
  localparam int NUM_IN    = 113;
  localparam int NUM_GATES = 40;
  localparam int NUM_OUT   = 2;
  localparam int IDX_W     = $clog2(2 + NUM_IN + NUM_GATES);
  localparam int ADDR_W    = $clog2(NUM_GATES);
  localparam int PROG_W    = 3 + 3 * IDX_W;
  localparam int GBASE     = NUM_IN + 2;

  logic               clk, rst_n;
  logic               in_valid, in_ready;
  logic [NUM_IN-1:0]  in_bits;
  logic               out_valid, out_ready;
  logic [NUM_OUT-1:0] out_bits;
  logic               busy;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [PROG_W-1:0]  prog_data;
  logic               prog_err;
`ifdef GATE_NET_STATS_EN
  logic [31:0]        stat_count;
  logic [15:0]        stat_rej;
`endif

  gate_net_seq_eval dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .busy(busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_err(prog_err)
`ifdef GATE_NET_STATS_EN
    , .stat_count(stat_count), .stat_rej(stat_rej)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int hs_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int m_done = 0;
  int m_rej = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the program as plain arrays, evaluated gate by gate in order.
  int                m_op [NUM_GATES];
  int                m_a  [NUM_GATES];
  int                m_b  [NUM_GATES];
  int                m_c  [NUM_GATES];
  logic [NUM_IN-1:0] m_x;
  bit                m_res [NUM_GATES];

  task automatic model_reset();
    for (int g = 0; g < NUM_GATES; g++) begin
      m_op[g] = 7; m_a[g] = 0; m_b[g] = 0; m_c[g] = 0;
    end
  endtask

  function automatic bit nv(input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 1) return 1'b1;
    if (idx < GBASE) return m_x[idx-2];
    if (idx < GBASE + NUM_GATES) return m_res[idx-GBASE];
    return 1'b0;
  endfunction

  function automatic logic [NUM_OUT-1:0] model_eval(input logic [NUM_IN-1:0] x);
    logic [NUM_OUT-1:0] o;
    bit a, b, c, r;
    m_x = x;
    for (int g = 0; g < NUM_GATES; g++) m_res[g] = 1'b0;
    for (int g = 0; g < NUM_GATES; g++) begin
      a = nv(m_a[g]); b = nv(m_b[g]); c = nv(m_c[g]);
      case (m_op[g])
        0: r = a & b;
        1: r = a | b;
        2: r = a ^ b;
        3: r = !(a & b);
        4: r = !(a | b);
        5: r = !(a ^ b);
        6: r = a | (b & c);
        default: r = a;
      endcase
      m_res[g] = r;
    end
    for (int k = 0; k < NUM_OUT; k++) o[k] = m_res[NUM_GATES-NUM_OUT+k];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PROG_W-1:0] pack(input int op, input int a, input int b, input int c);
    logic [2:0]       o3;
    logic [IDX_W-1:0] ia, ib, ic;
    o3 = op[2:0]; ia = a[IDX_W-1:0]; ib = b[IDX_W-1:0]; ic = c[IDX_W-1:0];
    return {o3, ia, ib, ic};
  endfunction

  task automatic prog_write(input int addr, input int op, input int a, input int b, input int c, input bit idle);
    bit exp_err;
    exp_err   = !idle || (addr >= NUM_GATES);
    prog_we   = 1'b1;
    prog_addr = ADDR_W'(addr);
    prog_data = pack(op, a, b, c);
    tick();
    prog_we = 1'b0;
    chk("prog_err", prog_err, exp_err);
    if (exp_err) m_rej++;
    else begin
      m_op[addr] = op; m_a[addr] = a; m_b[addr] = b; m_c[addr] = c;
    end
  endtask

  task automatic start_sample(input logic [NUM_IN-1:0] x);
    chk("in_ready_idle", in_ready, 1);
    in_bits  = x;
    in_valid = 1'b1;
    tick();
    hs_cyc   = cyc;
    in_valid = 1'b0;
  endtask

  task automatic finish_sample(input logic [NUM_OUT-1:0] exp, input string tag, input bit chk_lat);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, " out_valid"}, out_valid, 1);
    if (chk_lat) chk({tag, " latency"}, cyc - hs_cyc, NUM_GATES);
    chk({tag, " out_bits"}, out_bits, exp);
    out_ready = 1'b1;
    tick();
    if (n < 200) m_done++;
    chk({tag, " in_ready_after"}, in_ready, 1);
  endtask

  task automatic run_sample(input logic [NUM_IN-1:0] x, input logic [NUM_OUT-1:0] exp, input string tag);
    out_ready = 1'b1;
    start_sample(x);
    finish_sample(exp, tag, 1'b1);
  endtask

  function automatic logic [NUM_IN-1:0] rand_x();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[NUM_IN-1:0];
  endfunction

  function automatic logic [NUM_IN-1:0] bits3(input bit b0, input bit b1, input bit b2);
    logic [NUM_IN-1:0] x;
    x = '0; x[0] = b0; x[1] = b1; x[2] = b2;
    return x;
  endfunction

  function automatic int rand_src(input int g);
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, (1 << IDX_W) - 1));
    if ($urandom_range(0, 1) == 0) return GBASE + int'($urandom_range(0, g + 1));
    return int'($urandom_range(0, GBASE + g + 1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM_IN-1:0]  x, x1;
    logic [NUM_OUT-1:0] e1;

    rst_n = 1'b0; in_valid = 1'b0; in_bits = '0; out_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_bits", out_bits, 0);
    chk("rst busy", busy, 0);
    chk("rst prog_err", prog_err, 0);

    run_sample('1, 2'b00, "noprog");

    prog_write(0, 2, 2, 3, 0, 1'b1);
    for (int g = 1; g <= 37; g++) prog_write(g, 7, 0, 0, 0, 1'b1);
    prog_write(38, 7, GBASE, 0, 0, 1'b1);
    prog_write(39, 3, GBASE, 1, 0, 1'b1);
    run_sample(bits3(1, 0, 0), 2'b01, "xor10");
    run_sample(bits3(1, 1, 0), 2'b10, "xor11");

    prog_write(39, 6, 2, 3, 4, 1'b1);
    run_sample(bits3(1, 0, 0), 2'b11, "ao21_100");
    run_sample(bits3(0, 1, 1), 2'b11, "ao21_011");
    run_sample(bits3(0, 1, 0), 2'b01, "ao21_010");

    // Write accepted in the same cycle as the input handshake.
    x = rand_x();
    out_ready = 1'b1;
    prog_we = 1'b1; prog_addr = ADDR_W'(39); prog_data = pack(7, 1, 0, 0);
    in_bits = x; in_valid = 1'b1;
    tick();
    hs_cyc = cyc;
    prog_we = 1'b0; in_valid = 1'b0;
    chk("samecyc prog_err", prog_err, 0);
    m_op[39] = 7; m_a[39] = 1;
    finish_sample(model_eval(x), "samecyc", 1'b1);

    // Backpressure in DONE with a competing sample offered.
    x1 = rand_x();
    e1 = model_eval(x1);
    out_ready = 1'b0;
    start_sample(x1);
    finish_sample(e1, "bp_pre", 1'b0);
    out_ready = 1'b0;
    m_done--;
    start_sample(x1);
    for (int i = 0; i < 60 && !out_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_bits  = ~x1;
      tick();
      chk("bp out_valid", out_valid, 1);
      chk("bp out_bits", out_bits, e1);
      chk("bp in_ready", in_ready, 0);
      chk("bp busy", busy, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    m_done++;
    chk("bp release out_valid", out_valid, 0);
    chk("bp release busy", busy, 0);

    // Write during RUN must be rejected; it would otherwise clear out_bits[1].
    x = rand_x();
    start_sample(x);
    repeat (3) tick();
    prog_write(39, 0, 0, 0, 0, 1'b0);
    tick();
    chk("run prog_err width", prog_err, 0);
    finish_sample(model_eval(x), "run_wr", 1'b0);

    prog_write(NUM_GATES + 5, 0, 0, 0, 0, 1'b1);
    x = rand_x();
    run_sample(x, model_eval(x), "badaddr");

`ifdef GATE_NET_STATS_EN
    chk("stat_count", stat_count, m_done);
    chk("stat_rej", stat_rej, m_rej);
`endif

    // Reset in the middle of RUN.
    start_sample(rand_x());
    repeat (20) tick();
    chk("midrun busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun busy", busy, 0);
    chk("midrun out_valid", out_valid, 0);
    chk("midrun in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    model_reset();
    m_done = 0; m_rej = 0;
    tick();
    x = rand_x();
    run_sample(x, model_eval(x), "postrst");

    // Random programs with random inputs.
    for (int p = 0; p < 6; p++) begin
      for (int g = 0; g < NUM_GATES; g++) begin
        prog_write(g, int'($urandom_range(0, 7)), rand_src(g), rand_src(g), rand_src(g), 1'b1);
      end
      for (int s = 0; s < 4; s++) begin
        x = rand_x();
        run_sample(x, model_eval(x), "rand");
      end
    end

`ifdef GATE_NET_STATS_EN
    chk("stat_count_end", stat_count, m_done);
    chk("stat_rej_end", stat_rej, m_rej);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
